proc_ctrl: RTL and testbench
============================

Name: proc_ctrl

Overview:
Multi-cycle control FSM for the 16-bit register/bus datapath. Sequences the 9-input bus mux (R0-R7 plus immediate), the register-file write enables, the A/G ALU registers and the ALU op.
- Captures a 9-bit instruction on `run`.
- Executes it in 2-4 cycles.
- Reports `done`.
- Sits between the instruction source and the datapath. It has no data path of its own.

Parameters:
- IR_W, 9, instruction width: op[8:6], rX[5:3], rY[2:0].
- NREG, 8, number of general registers; one write enable each.
- SEL_IMM, 8, bus-mux select value for the immediate/DIN input.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active low
- run  in  1  start request; sampled only in IDLE
- ir_in  in  IR_W  instruction word; captured when run=1 in IDLE
- mux_sel  out  4  bus-mux select: 0-7 = R0-R7, 8 = immediate
- r_we  out  NREG  one-hot register write enable
- wb_sel  out  1  register write-data source: 0 = bus, 1 = G
- a_we  out  1  load A register from bus
- g_we  out  1  load G register from ALU
- alu_op  out  2  ALU function: 0 ADD, 1 SUB, 2 AND, 3 pass A
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse in the final cycle of an instruction
- illegal  out  1  one-cycle pulse with done for an undefined opcode

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state <- IDLE, IR <- 0.
  - All outputs are 0 in the reset cycle and in IDLE: mux_sel=0, r_we=0, wb_sel=0, a_we=0, g_we=0, alu_op=0, busy=0, done=0, illegal=0.
  - Reset mid-instruction aborts it. No write enable is asserted after the edge that samples rst_n=0.
- Outputs are decoded from the registered state and the internal IR only. No combinational path from run or ir_in to any output.
- States: IDLE, T1, T2, T3.
  - IDLE: if run=1, IR <- ir_in and go to T1. Otherwise stay in IDLE.
  - T1, by opcode:
    - mv (000): mux_sel=rY, r_we[rX]=1, wb_sel=0, done=1, then IDLE.
    - mvi (001): mux_sel=SEL_IMM, r_we[rX]=1, wb_sel=0, done=1, then IDLE.
    - add (010), sub (011), and (100): mux_sel=rX, a_we=1, then T2.
    - 101-111: no enables, done=1, illegal=1, then IDLE.
  - T2: mux_sel=rY, alu_op per opcode (010->0, 011->1, 100->2), g_we=1, then T3.
  - T3: wb_sel=1, r_we[rX]=1, done=1, then IDLE.
- Latency from the run edge to done: mv/mvi/illegal = 1 cycle (done in T1); ALU ops = 3 cycles (done in T3).
- `run` outside IDLE is ignored; it is not queued. Back-to-back instructions are allowed: run=1 in the cycle after done starts the next one. Minimum period is 2 cycles per mv.
- r_we is always one-hot or zero; never more than one register is written per cycle.
- rX=rY is legal (e.g. add R2,R2 doubles R2). A is loaded in T1, so the T2 bus read of rY is unaffected.
- ir_in changes after capture have no effect.

Decomposition:
- Package proc_pkg holds:
  - opcode constants OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND
  - ALU op constants ALU_ADD, ALU_SUB, ALU_AND, ALU_PASS
  - SEL_IMM
  - state enum (IDLE, T1, T2, T3)
- One natural sub-module: proc_ctrl_dec, a purely combinational decoder mapping (state, IR) to the output bundle. proc_ctrl keeps the state and IR registers.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with run=1 -> all outputs 0, busy=0. Release -> first instruction captured on the next run edge.
- mvi R3 (ir_in=9'b001_011_000), run pulse -> next cycle mux_sel=8, r_we=8'b0000_1000, wb_sel=0, done=1. Following cycle busy=0.
- add R1,R2 (9'b010_001_010):
  - T1: mux_sel=1, a_we=1.
  - T2: mux_sel=2, alu_op=0, g_we=1.
  - T3: wb_sel=1, r_we=8'b0000_0010, done=1.
  - Exactly one done pulse.
- sub R5,R5 with run held high throughout -> T1/T2/T3 sequence as above with alu_op=1. The next instruction starts only after IDLE is re-entered; run in T1-T3 is ignored.
- Illegal 9'b111_000_000 -> one cycle later done=1, illegal=1, r_we=0, a_we=0, g_we=0.
- Reset asserted in T2 of an add -> next cycle IDLE, r_we never asserted, done never pulsed.

Source files
------------

// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the multi-cycle bus/register controller: opcodes, ALU
// functions, FSM states and the control-word bundle driven to the datapath.
package proc_pkg;
    localparam int IR_W = 9;
    localparam int NREG = 8;
    localparam logic [3:0] SEL_IMM = 4'd8;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_AND  = 2'd2;
    localparam logic [1:0] ALU_PASS = 2'd3;

    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    typedef struct packed {
        logic [3:0]      mux_sel;
        logic [NREG-1:0] r_we;
        logic            wb_sel;
        logic            a_we;
        logic            g_we;
        logic [1:0]      alu_op;
        logic            busy;
        logic            done;
        logic            illegal;
    } ctrl_t;

    function automatic logic is_alu_op(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
    endfunction

    function automatic logic [NREG-1:0] reg_onehot(input logic [2:0] idx);
        logic [NREG-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Only reached for ALU opcodes; the pass-through code is a safe fallback.
    function automatic logic [1:0] alu_of(input logic [2:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            default: return ALU_PASS;
        endcase
    endfunction
endpackage

// File: rtl/proc_ctrl_if.sv
// Connection between the instruction source (master) and the controller (slave),
// carrying the start request plus every datapath control line.
interface proc_ctrl_if;
    import proc_pkg::*;

    // Handshake: the source raises run with ir_in valid; it is accepted on a clock
    // edge only while busy=0. done pulses for one cycle in the final execute cycle,
    // and run is next accepted in the cycle that follows. run while busy is dropped.
    logic            run;
    logic [IR_W-1:0] ir_in;
    logic [3:0]      mux_sel;
    logic [NREG-1:0] r_we;
    logic            wb_sel;
    logic            a_we;
    logic            g_we;
    logic [1:0]      alu_op;
    logic            busy;
    logic            done;
    logic            illegal;

    modport master (
        output run, ir_in,
        input  mux_sel, r_we, wb_sel, a_we, g_we, alu_op, busy, done, illegal
    );

    modport slave (
        input  run, ir_in,
        output mux_sel, r_we, wb_sel, a_we, g_we, alu_op, busy, done, illegal
    );
endinterface

// File: rtl/proc_ctrl_dec.sv
// Purely combinational decode of (state, captured instruction) into the datapath
// control word. Nothing here looks at run or ir_in.
module proc_ctrl_dec
    import proc_pkg::*;
(
    input  state_t          state,
    input  logic [IR_W-1:0] ir,
    output ctrl_t           ctrl
);
    logic [2:0] op;
    logic [2:0] rx;
    logic [2:0] ry;

    assign op = ir[8:6];
    assign rx = ir[5:3];
    assign ry = ir[2:0];

    always_comb begin
        ctrl = '0;
        unique case (state)
            IDLE: ;
            T1: begin
                ctrl.busy = 1'b1;
                case (op)
                    OP_MV: begin
                        ctrl.mux_sel = {1'b0, ry};
                        ctrl.r_we    = reg_onehot(rx);
                        ctrl.done    = 1'b1;
                    end
                    OP_MVI: begin
                        ctrl.mux_sel = SEL_IMM;
                        ctrl.r_we    = reg_onehot(rx);
                        ctrl.done    = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        ctrl.mux_sel = {1'b0, rx};
                        ctrl.a_we    = 1'b1;
                    end
                    default: begin
                        ctrl.done    = 1'b1;
                        ctrl.illegal = 1'b1;
                    end
                endcase
            end
            // A already holds rX from T1, so rX==rY reads the same register twice safely.
            T2: begin
                ctrl.busy    = 1'b1;
                ctrl.mux_sel = {1'b0, ry};
                ctrl.alu_op  = alu_of(op);
                ctrl.g_we    = 1'b1;
            end
            T3: begin
                ctrl.busy   = 1'b1;
                ctrl.wb_sel = 1'b1;
                ctrl.r_we   = reg_onehot(rx);
                ctrl.done   = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/proc_ctrl.sv
// Multi-cycle controller: holds the FSM state and instruction register, and
// exposes the registered state for observation alongside the decoded controls.
module proc_ctrl
    import proc_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    proc_ctrl_if.slave bus,
    output state_t fsm_state
);
    state_t          state;
    state_t          next_state;
    logic [IR_W-1:0] ir;
    ctrl_t           ctrl;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && bus.run)
                ir <= bus.ir_in;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (bus.run) next_state = T1;
            T1:   next_state = is_alu_op(ir[8:6]) ? T2 : IDLE;
            T2:   next_state = T3;
            T3:   next_state = IDLE;
        endcase
    end

    proc_ctrl_dec u_dec (
        .state (state),
        .ir    (ir),
        .ctrl  (ctrl)
    );

    assign bus.mux_sel = ctrl.mux_sel;
    assign bus.r_we    = ctrl.r_we;
    assign bus.wb_sel  = ctrl.wb_sel;
    assign bus.a_we    = ctrl.a_we;
    assign bus.g_we    = ctrl.g_we;
    assign bus.alu_op  = ctrl.alu_op;
    assign bus.busy    = ctrl.busy;
    assign bus.done    = ctrl.done;
    assign bus.illegal = ctrl.illegal;
    assign fsm_state   = state;
endmodule

// File: tb/tb_proc_ctrl.sv
// Bench for proc_ctrl: instruction-level model expanding each accepted instruction
// into its per-cycle control words, checked every cycle, plus literal spot checks.
module tb_proc_ctrl;
    import proc_pkg::*;

    localparam int W = 20;

    logic   clk;
    logic   rst_n;
    state_t fsm_state;

    proc_ctrl_if bus();

    proc_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // model: an instruction becomes a list of control words, one per cycle
    function automatic logic [W-1:0] pack(input logic [3:0] mux, input logic [7:0] rwe,
                                          input logic wb, input logic a, input logic g,
                                          input logic [1:0] alu, input logic bsy,
                                          input logic dn, input logic ill);
        return {mux, rwe, wb, a, g, alu, bsy, dn, ill};
    endfunction

    function automatic int exp_len(input logic [8:0] ir);
        int op;
        op = int'(ir[8:6]);
        if (op <= 1 || op >= 5) return 1;
        return 3;
    endfunction

    function automatic logic [W-1:0] exp_step(input logic [8:0] ir, input int step);
        int op, rx, ry;
        logic [7:0] wr;
        op = int'(ir[8:6]);
        rx = int'(ir[5:3]);
        ry = int'(ir[2:0]);
        wr = 8'(1 << rx);
        if (op == 0) return pack(4'(ry), wr, 0, 0, 0, 2'd0, 1, 1, 0);
        if (op == 1) return pack(4'd8, wr, 0, 0, 0, 2'd0, 1, 1, 0);
        if (op >= 5) return pack(4'd0, 8'd0, 0, 0, 0, 2'd0, 1, 1, 1);
        if (step == 0) return pack(4'(rx), 8'd0, 0, 1, 0, 2'd0, 1, 0, 0);
        if (step == 1) return pack(4'(ry), 8'd0, 0, 0, 1, 2'(op - 2), 1, 0, 0);
        return pack(4'd0, wr, 1, 0, 0, 2'd0, 1, 1, 0);
    endfunction

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_now = '0;
    logic         chk_en  = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_now = '0;
            chk_en  = 1'b1;
        end else begin
            if (exp_now[2] == 1'b0 && bus.run) begin
                for (int i = 0; i < exp_len(bus.ir_in); i++)
                    exp_q.push_back(exp_step(bus.ir_in, i));
            end
            exp_now = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        end
    end

    // scoreboard compare, every cycle away from the active edge
    int   done_cnt  = 0;
    logic rwe_seen  = 1'b0;
    logic [W-1:0] act_vec;

    always @(negedge clk) begin
        if (chk_en) begin
            act_vec = {bus.mux_sel, bus.r_we, bus.wb_sel, bus.a_we, bus.g_we,
                       bus.alu_op, bus.busy, bus.done, bus.illegal};
            chk("cycle_ctrl", 32'(act_vec), 32'(exp_now));
            if (bus.done) done_cnt++;
            if (bus.r_we != 8'd0) rwe_seen = 1'b1;
        end
    end

    // driver tasks
    task automatic issue(input logic [8:0] ir);
        bus.run   = 1'b1;
        bus.ir_in = ir;
        @(negedge clk);
        bus.run   = 1'b0;
        bus.ir_in = 9'($urandom_range(0, 511));
    endtask

    logic [8:0] tbl [6] = '{9'b100_000_111, 9'b000_010_010, 9'b010_010_010,
                            9'b101_001_001, 9'b110_111_111, 9'b001_111_000};
    int done_before;

    initial begin
        // model pins
        chk("pin_len_add", 32'(exp_len(9'b010_001_010)), 32'd3);
        chk("pin_len_mv", 32'(exp_len(9'b000_001_010)), 32'd1);
        chk("pin_mvi_r3", 32'(exp_step(9'b001_011_000, 0)), 32'({4'd8, 8'h08, 3'b000, 2'd0, 3'b110}));
        chk("pin_add_t2", 32'(exp_step(9'b010_001_010, 1)), 32'({4'd2, 8'h00, 3'b001, 2'd0, 3'b100}));
        chk("pin_sub_t2", 32'(exp_step(9'b011_101_101, 1)), 32'({4'd5, 8'h00, 3'b001, 2'd1, 3'b100}));
        chk("pin_ill", 32'(exp_step(9'b111_000_000, 0)), 32'({4'd0, 8'h00, 3'b000, 2'd0, 3'b111}));

        // reset held 2 cycles with run=1
        rst_n     = 1'b0;
        bus.run   = 1'b1;
        bus.ir_in = 9'b001_011_000;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_rwe", 32'(bus.r_we), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_state", 32'(fsm_state), 32'(IDLE));
        rst_n   = 1'b1;
        bus.run = 1'b0;
        @(negedge clk);

        // mvi R3
        issue(9'b001_011_000);
        chk("mvi_mux", 32'(bus.mux_sel), 32'd8);
        chk("mvi_rwe", 32'(bus.r_we), 32'h08);
        chk("mvi_wb", 32'(bus.wb_sel), 32'd0);
        chk("mvi_done", 32'(bus.done), 32'd1);
        @(negedge clk);
        chk("mvi_idle", 32'(bus.busy), 32'd0);

        // add R1,R2
        done_before = done_cnt;
        issue(9'b010_001_010);
        chk("add_t1_mux", 32'(bus.mux_sel), 32'd1);
        chk("add_t1_awe", 32'(bus.a_we), 32'd1);
        @(negedge clk);
        chk("add_t2_mux", 32'(bus.mux_sel), 32'd2);
        chk("add_t2_alu", 32'(bus.alu_op), 32'd0);
        chk("add_t2_gwe", 32'(bus.g_we), 32'd1);
        @(negedge clk);
        chk("add_t3_wb", 32'(bus.wb_sel), 32'd1);
        chk("add_t3_rwe", 32'(bus.r_we), 32'h02);
        chk("add_t3_done", 32'(bus.done), 32'd1);
        @(negedge clk);
        chk("add_one_done", 32'(done_cnt - done_before), 32'd1);

        // sub R5,R5 with run held; a second instruction waits for IDLE
        bus.run   = 1'b1;
        bus.ir_in = 9'b011_101_101;
        @(negedge clk);
        chk("sub_t1_mux", 32'(bus.mux_sel), 32'd5);
        bus.ir_in = 9'b001_000_000;
        @(negedge clk);
        chk("sub_t2_alu", 32'(bus.alu_op), 32'd1);
        chk("sub_t2_mux", 32'(bus.mux_sel), 32'd5);
        @(negedge clk);
        chk("sub_t3_rwe", 32'(bus.r_we), 32'h20);
        @(negedge clk);
        chk("sub_then_idle", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("next_mvi_mux", 32'(bus.mux_sel), 32'd8);
        chk("next_mvi_rwe", 32'(bus.r_we), 32'h01);
        bus.run = 1'b0;
        @(negedge clk);

        // illegal opcode
        issue(9'b111_000_000);
        chk("ill_done", 32'(bus.done), 32'd1);
        chk("ill_flag", 32'(bus.illegal), 32'd1);
        chk("ill_en", 32'({bus.r_we, bus.a_we, bus.g_we}), 32'd0);
        @(negedge clk);

        // back-to-back mv at the 2-cycle minimum period
        issue(9'b000_111_100);
        chk("mv_rwe", 32'(bus.r_we), 32'h80);
        @(negedge clk);
        issue(9'b000_000_111);
        chk("mv2_mux", 32'(bus.mux_sel), 32'd7);
        @(negedge clk);

        // reset during T2 of an add
        issue(9'b010_100_110);
        @(negedge clk);
        rst_n       = 1'b0;
        done_before = done_cnt;
        rwe_seen    = 1'b0;
        @(negedge clk);
        chk("abort_state", 32'(fsm_state), 32'(IDLE));
        chk("abort_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - done_before), 32'd0);
        chk("abort_no_rwe", 32'(rwe_seen), 32'd0);

        // table of further instructions, checked cycle by cycle by the model
        for (int i = 0; i < 6; i++) begin
            issue(tbl[i]);
            for (int c = 0; c < 6 && exp_now[2]; c++) @(negedge clk);
            chk("tbl_idle", 32'(bus.busy), 32'd0);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
